// File: rtl/cache_plru_pkg.sv
// Shared types and tree helpers for the per-bank pseudo-LRU state store.
// Heap-ordered tree: node 0 is the root, children of node i are 2i+1 / 2i+2.
package cache_plru_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } plru_state_e;

    function automatic int lru_width(input int ways);
        return (ways - 1 > 0) ? ways - 1 : 1;
    endfunction

    function automatic int way_sel_width(input int ways);
        return ($clog2(ways) > 0) ? $clog2(ways) : 1;
    endfunction

    // dir=1 selects the right child (way bit 1 at that level)
    function automatic int node_child(input int node, input logic dir);
        return 2 * node + 1 + int'(dir);
    endfunction

    function automatic int node_parent(input int node);
        return (node - 1) / 2;
    endfunction

    function automatic int node_depth(input int node);
        int d;
        int n;
        d = 0;
        n = node;
        for (int i = 0; i < 32; i++) begin
            if (n > 0) begin
                n = (n - 1) / 2;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/cache_plru_path_dec.sv
// Decodes a touched way into the masked tree update along its root-to-leaf path.
// Each path node is set to point away from the touched way.
module cache_plru_path_dec
    import cache_plru_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int WAY_SEL_WIDTH = way_sel_width(NUM_WAYS),
    parameter int LRU_WIDTH     = lru_width(NUM_WAYS)
) (
    input  logic [WAY_SEL_WIDTH-1:0] way,
    output logic [LRU_WIDTH-1:0]     data,
    output logic [LRU_WIDTH-1:0]     mask
);

    always_comb begin
        int   node;
        logic dir;
        data = '0;
        mask = '0;
        node = 0;
        dir  = 1'b0;
        for (int d = 0; d < WAY_SEL_WIDTH; d++) begin
            dir  = |((way >> (WAY_SEL_WIDTH - 1 - d)) & WAY_SEL_WIDTH'(1));
            mask = mask | (LRU_WIDTH'(1) << node);
            if (!dir)
                data = data | (LRU_WIDTH'(1) << node);
            node = node_child(node, dir);
        end
    end

endmodule

// File: rtl/cache_plru_store.sv
// Per-bank PLRU tree store: clear sweep, masked touch updates, registered reads + victim.
// Define CACHE_PLRU_BYPASS_EN to forward a same-cycle same-line touch into the read.
module cache_plru_store
    import cache_plru_pkg::*;
#(
    parameter int NUM_LINES     = 64,
    parameter int NUM_WAYS      = 4,
    parameter int LINE_SEL_BITS = $clog2(NUM_LINES),
    parameter int WAY_SEL_WIDTH = way_sel_width(NUM_WAYS),
    parameter int LRU_WIDTH     = lru_width(NUM_WAYS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     stall,
    output logic                     init_done,
    input  logic                     touch_valid,
    input  logic [LINE_SEL_BITS-1:0] touch_line,
    input  logic [WAY_SEL_WIDTH-1:0] touch_way,
    input  logic                     read_valid,
    input  logic [LINE_SEL_BITS-1:0] read_line,
    output logic [LRU_WIDTH-1:0]     read_lru,
    output logic [WAY_SEL_WIDTH-1:0] victim_way
);

    localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(NUM_LINES - 1);

    plru_state_e              state;
    logic [LINE_SEL_BITS-1:0] sweep_cnt;
    logic [LRU_WIDTH-1:0]     tree_mem [NUM_LINES];
    logic [LRU_WIDTH-1:0]     path_data;
    logic [LRU_WIDTH-1:0]     path_mask;
    logic [LRU_WIDTH-1:0]     touch_new;
    logic [LRU_WIDTH-1:0]     rd_data;
    logic                     touch_en;
    logic                     read_en;

    cache_plru_path_dec #(
        .NUM_WAYS      (NUM_WAYS),
        .WAY_SEL_WIDTH (WAY_SEL_WIDTH),
        .LRU_WIDTH     (LRU_WIDTH)
    ) u_path_dec (
        .way  (touch_way),
        .data (path_data),
        .mask (path_mask)
    );

    // A flush cycle drops any request presented alongside it
    assign touch_en  = (state == READY) && touch_valid && !stall && !flush;
    assign read_en   = (state == READY) && read_valid  && !stall && !flush;
    assign touch_new = (tree_mem[touch_line] & ~path_mask) | (path_data & path_mask);

`ifdef CACHE_PLRU_BYPASS_EN
    assign rd_data = (touch_en && (touch_line == read_line)) ? touch_new : tree_mem[read_line];
`else
    assign rd_data = tree_mem[read_line];
`endif

    // Storage has no reset of its own; the sweep is what clears it
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT)
                tree_mem[sweep_cnt] <= '0;
            else if (touch_en)
                tree_mem[touch_line] <= touch_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            sweep_cnt <= '0;
            read_lru  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    read_lru  <= '0;
                    sweep_cnt <= sweep_cnt + LINE_SEL_BITS'(1);
                    if (sweep_cnt == LAST_LINE) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    if (flush) begin
                        state     <= INIT;
                        sweep_cnt <= '0;
                        read_lru  <= '0;
                        init_done <= 1'b0;
                    end else if (read_en) begin
                        read_lru  <= rd_data;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Walk from the root following the stored bits; node 0 gives the way MSB
    always_comb begin
        int   node;
        logic dir;
        victim_way = '0;
        node       = 0;
        dir        = 1'b0;
        for (int d = 0; d < WAY_SEL_WIDTH; d++) begin
            dir        = |(read_lru & (LRU_WIDTH'(1) << node));
            victim_way = victim_way | (WAY_SEL_WIDTH'(dir) << (WAY_SEL_WIDTH - 1 - d));
            node       = node_child(node, dir);
        end
    end

endmodule

// File: tb/tb_cache_plru_store.sv
// Bench for cache_plru_store (64 lines, 4 ways): vector table, corner sequences,
// and a random run, all checked against a 4-way tree model through a read scoreboard.
module tb_cache_plru_store;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       stall;
    logic       init_done;
    logic       touch_valid;
    logic [5:0] touch_line;
    logic [1:0] touch_way;
    logic       read_valid;
    logic [5:0] read_line;
    logic [2:0] read_lru;
    logic [1:0] victim_way;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_mem [64];
    logic [2:0] m_rd;
    logic       m_ready;
    logic [2:0] sb [$];

    typedef struct {
        logic [5:0] line;
        logic [1:0] way;
        logic [2:0] lru;
        logic [1:0] vic;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    cache_plru_store dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .stall       (stall),
        .init_done   (init_done),
        .touch_valid (touch_valid),
        .touch_line  (touch_line),
        .touch_way   (touch_way),
        .read_valid  (read_valid),
        .read_line   (read_line),
        .read_lru    (read_lru),
        .victim_way  (victim_way)
    );

    // 4-way tree: bit0 root, bit1 covers ways 0/1, bit2 covers ways 2/3
    function automatic logic [2:0] touched(input logic [2:0] t, input logic [1:0] w);
        logic [2:0] r;
        r    = t;
        r[0] = ~w[1];
        if (w[1]) r[2] = ~w[0];
        else      r[1] = ~w[0];
        return r;
    endfunction

    function automatic logic [1:0] enc(input logic [2:0] t);
        return {t[0], (t[0] ? t[2] : t[1])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < 64; i++) m_mem[i] = 3'b000;
    endtask

    // One clock: drive, update model/scoreboard, then check the registered read
    task automatic step(input logic tv, input logic [5:0] tl, input logic [1:0] tw,
                        input logic rv, input logic [5:0] rl, input logic st, input logic fl);
        logic       acc;
        logic       fl_acc;
        logic [2:0] exp;
        touch_valid = tv; touch_line = tl; touch_way = tw;
        read_valid  = rv; read_line  = rl; stall = st; flush = fl;
        fl_acc = m_ready && fl;
        acc    = m_ready && !st && !fl;
        if (acc && rv) begin
            exp = m_mem[rl];
`ifdef CACHE_PLRU_BYPASS_EN
            if (tv && tl == rl) exp = touched(m_mem[tl], tw);
`endif
            sb.push_back(exp);
        end
        if (acc && tv) m_mem[tl] = touched(m_mem[tl], tw);
        if (fl_acc) begin
            m_ready = 1'b0;
            zero_model();
        end
        @(posedge clk);
        #1;
        if (fl_acc) m_rd = 3'b000;
        if (sb.size() > 0) m_rd = sb.pop_front();
        chk("read_lru", 32'(read_lru), 32'(m_rd));
        chk("victim_way", 32'(victim_way), 32'(enc(m_rd)));
        flush = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        touch_valid = 1'b0; read_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = 1'b0;
        m_rd    = 3'b000;
        sb.delete();
        zero_model();
        chk("reset_init_done", 32'(init_done), 32'd0);
        chk("reset_read_lru", 32'(read_lru), 32'd0);
    endtask

    // Sweep length check with junk traffic (and stalls) that must all be dropped
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!init_done && n < 200) begin
            step(1'b1, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                 1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        chk(name, 32'(n), 32'd64);
        m_ready = 1'b1;
    endtask

    initial begin
        tbl[0] = '{6'd5,  2'd0, 3'b011, 2'd2};
        tbl[1] = '{6'd5,  2'd2, 3'b110, 2'd1};
        tbl[2] = '{6'd9,  2'd1, 3'b001, 2'd2};
        tbl[3] = '{6'd9,  2'd3, 3'b000, 2'd0};
        tbl[4] = '{6'd12, 2'd3, 3'b000, 2'd0};
        tbl[5] = '{6'd12, 2'd2, 3'b100, 2'd0};
        tbl[6] = '{6'd12, 2'd0, 3'b111, 2'd3};
        tbl[7] = '{6'd5,  2'd1, 3'b101, 2'd3};

        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        touch_valid = 1'b0; touch_line = '0; touch_way = '0;
        read_valid = 1'b0; read_line = '0;
        m_ready = 1'b0; m_rd = 3'b000;
        zero_model();
        #2;
        do_reset();
        wait_ready("init_len");
        chk("init_done_high", 32'(init_done), 32'd1);

        // Touch then read, against hand-derived tree values
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].line, tbl[i].way, 1'b0, 6'd0, 1'b0, 1'b0);
            step(1'b0, 6'd0, 2'd0, 1'b1, tbl[i].line, 1'b0, 1'b0);
            chk("tbl_lru", 32'(read_lru), 32'(tbl[i].lru));
            chk("tbl_victim", 32'(victim_way), 32'(tbl[i].vic));
        end

        // Same-cycle touch + read of one line
        step(1'b1, 6'd20, 2'd0, 1'b1, 6'd20, 1'b0, 1'b0);
`ifdef CACHE_PLRU_BYPASS_EN
        chk("same_cycle_lru", 32'(read_lru), 32'h3);
`else
        chk("same_cycle_lru", 32'(read_lru), 32'h0);
`endif
        step(1'b0, 6'd0, 2'd0, 1'b1, 6'd20, 1'b0, 1'b0);
        chk("after_same_cycle", 32'(read_lru), 32'h3);

        // Stall freezes both the touch and the read capture
        step(1'b1, 6'd7, 2'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 6'd0, 2'd0, 1'b1, 6'd5, 1'b0, 1'b0);
        step(1'b1, 6'd7, 2'd3, 1'b1, 6'd7, 1'b1, 1'b0);
        chk("stall_hold", 32'(read_lru), 32'h5);
        step(1'b0, 6'd0, 2'd0, 1'b1, 6'd7, 1'b0, 1'b0);
        chk("stall_no_commit", 32'(read_lru), 32'h3);
        step(1'b1, 6'd7, 2'd3, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 6'd0, 2'd0, 1'b1, 6'd7, 1'b0, 1'b0);
        chk("unstall_commit", 32'(read_lru), 32'h2);

        // Flush together with a touch: touch dropped, full sweep, all lines zero
        step(1'b1, 6'd5, 2'd0, 1'b1, 6'd5, 1'b0, 1'b1);
        chk("flush_init_done", 32'(init_done), 32'd0);
        wait_ready("flush_len");
        for (int i = 0; i < 64; i++)
            step(1'b0, 6'd0, 2'd0, 1'b1, 6'(i), 1'b0, 1'b0);
        chk("flush_line5", 32'(read_lru), 32'd0);
        idle();

        // Reset mid-sweep at line 30 restarts the full sweep
        step(1'b0, 6'd0, 2'd0, 1'b0, 6'd0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) idle();
        do_reset();
        wait_ready("reset_mid_len");

        // Random traffic on a few lines so collisions are common
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) == 0), 1'b0);
        idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_plru_store.md
Name: cache_plru_store

Overview:
Per-bank pseudo-LRU state store for set-associative caches: the writer side of the PLRU protocol. It owns the per-line PLRU tree bits and applies masked tree updates on every hit or fill ("touch"). It serves registered reads of the tree plus the encoded victim way to the replacement/fill path. A reset/flush sweep FSM clears all lines before the cache accepts traffic.

Parameters:
NUM_LINES, 64, lines per bank (power of 2, >=2)
NUM_WAYS, 4, associativity (power of 2, >=2)
LINE_SEL_BITS, $clog2(NUM_LINES), line index width
WAY_SEL_WIDTH, `UP($clog2(NUM_WAYS)), way index width
LRU_WIDTH, `UP(NUM_WAYS-1), tree bits per line

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  restart clear sweep (honoured in READY only)
stall  in  1  freezes touch commit and read capture
init_done  out  1  high in READY state
touch_valid  in  1  hit/fill update request
touch_line  in  LINE_SEL_BITS  line to update
touch_way  in  WAY_SEL_WIDTH  way just accessed
read_valid  in  1  victim lookup request
read_line  in  LINE_SEL_BITS  line to read
read_lru  out  LRU_WIDTH  tree bits of read_line, 1-cycle latency
victim_way  out  WAY_SEL_WIDTH  way encoded from read_lru (combinational from read_lru register)

Behaviour:
- Clock clk; reset synchronous, active-high.
- Tree layout: heap order. Node 0 is the root; children of node i are 2i+1 (way MSB=0) and 2i+2 (way MSB=1). A node bit of 1 selects the right child as victim.
- States: INIT, READY. Reset sets INIT, sweep counter=0, read_lru=0, init_done=0.
- INIT: each cycle writes all-zero tree to line[counter], then counter++. After the write of line NUM_LINES-1, go to READY next cycle (init_done=1). The sweep takes exactly NUM_LINES cycles and ignores stall.
- INIT: touch and read requests are dropped; read_lru and victim_way stay 0.
- Reset asserted mid-sweep or in READY restarts the sweep from line 0.
- READY + flush: enter INIT, counter=0. Any touch or read in the same cycle is dropped. flush is ignored while already in INIT.
- Touch (READY, touch_valid, ~stall): masked write on the root-to-leaf path of touch_way. For a node at depth d, data = ~touch_way bit (WAY_SEL_WIDTH-1-d), pointing away from the touched way. Only path nodes are written; off-path bits are unchanged. The write is committed at the next posedge.
- Read (READY, read_valid, ~stall): read_line is captured, and read_lru is updated at the next posedge.
- read_lru holds its value when read_valid=0 or stall=1.
- victim_way: start at root and follow node bits for WAY_SEL_WIDTH levels. MSB = node 0 bit.
- Same-line touch and read in the same cycle: see the optional feature below.
- Touches to distinct lines never disturb each other.
- Back-to-back touches to one line each apply to the stored value, so the effect is cumulative.

Optional Feature:
CACHE_PLRU_BYPASS_EN:
- Defined: a same-cycle same-line read returns the post-touch tree (write-forwarded).
- Undefined: the read returns the pre-touch tree ("R" read-during-write mode). The update is still committed and is visible to the next read.

Decomposition:
- Package cache_plru_pkg: LRU_WIDTH and WAY_SEL_WIDTH helper functions, the state enum (INIT/READY), and node-index helpers (parent/child/depth).
- Sub-module cache_plru_path_dec: combinational touch_way -> {data, mask} path decoder. It is instantiated once; the victim encoder stays inline.

Test Plan:
1. reset 1 cycle, NUM_LINES=64 -> init_done rises exactly 64 cycles after reset deassert; a read of any line during the sweep returns read_lru=0.
2. NUM_WAYS=4, line 5: touch way 0, then read -> read_lru=3'b011, victim_way=2. Then touch way 2, then read -> read_lru=3'b110, victim_way=1.
3. Same-cycle touch way 0 + read of line 5 from zero state -> with CACHE_PLRU_BYPASS_EN, read_lru=3'b011; without, 3'b000 and the next read returns 3'b011.
4. stall=1 with touch way 3 and read on line 7 -> no state change; read_lru holds its prior value. Deassert stall -> the touch commits, giving line 7 = 3'b000 (node0=0, node2=0).
5. flush in READY together with a touch -> the touch is dropped, init_done=0 for 64 cycles, and every line reads 0 afterwards. Reset asserted at sweep line 30 -> the sweep restarts and takes a full 64 cycles.
6. Random touches/reads over 10k cycles against a scoreboard tree model -> read_lru and victim_way match every cycle.
